// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI master/slave pair.
//
//   spi_state_e     : frame state of the slave (IDLE between frames, ACTIVE
//                     while chip select is held low).
//   SPI_DATA_WIDTH  : default word length in bits (MSB first).
//   SPI_SYNC_STAGES : default number of synchronizer flops per input pin.
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   localparam int SPI_DATA_WIDTH  = 8;
   localparam int SPI_SYNC_STAGES = 2;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
//   Single-bit synchronizer: STAGES flops in series on clk.
//
//   Ports:
//     clk : system clock
//     d   : asynchronous input pin
//     q   : synchronized copy of d, STAGES clk cycles late
//
//   The chain has no reset on purpose: it keeps tracking the pin while the
//   rest of the design is held in reset, so releasing reset in the middle of
//   a frame never fabricates a chip-select edge.
// -----------------------------------------------------------------------------
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx_tx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_tx
//   SPI mode-0 responder (CPOL=0, CPHA=0). The SCLK, CS_N and MOSI pins are
//   oversampled on clk; MOSI is deserialized into DATA_WIDTH-bit words (MSB
//   first) and a preloaded word is serialized onto MISO.
//
//   Parameters:
//     DATA_WIDTH  : word length, >= 2
//     SYNC_STAGES : synchronizer depth per pin, >= 2
//
//   Ports:
//     clk, rst     : system clock, synchronous active-high reset
//     spi_sclk     : serial clock from the master (asynchronous)
//     spi_cs_n     : chip select, active low (asynchronous)
//     spi_mosi     : master-out data (asynchronous)
//     spi_miso     : slave-out data
//     spi_miso_oe  : MISO output enable, high while a frame is active
//     tx_data      : next word to transmit
//     tx_valid     : tx_data valid
//     tx_ready     : one-deep TX buffer is empty
//     rx_data      : last complete received word
//     rx_valid     : one-cycle pulse, rx_data was just updated
//     busy         : frame state is ACTIVE
//
//   Optional build macro SPI_SLAVE_STATUS_EN adds:
//     tx_underrun  : one-cycle pulse on each load taken with the buffer empty
//     rx_abort     : one-cycle pulse when CS_N rises mid-word
//
//   TX handshake: a word transfers on a clk edge where tx_valid and tx_ready
//   are both high; tx_data must be stable while tx_valid is high. There is no
//   backpressure on rx_data: the consumer must take it on rx_valid.
// -----------------------------------------------------------------------------
module spi_slave_rx_tx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
`ifdef SPI_SLAVE_STATUS_EN
   ,
   output logic                  tx_underrun,
   output logic                  rx_abort
`endif
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   // ---------------------------------------------------------------------
   // Pin synchronizers and edge strobes
   // ---------------------------------------------------------------------
   logic sclk_s, cs_n_s, mosi_s;
   logic sclk_d, cs_n_d;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .d(spi_sclk), .q(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (.clk(clk), .d(spi_cs_n), .q(cs_n_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .d(spi_mosi), .q(mosi_s));

   // Edge-detect flops follow the synchronizers and, like them, keep tracking
   // through reset so no stale edge is seen when reset is released.
   always_ff @(posedge clk) begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
   end

   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   assign sclk_rise =  sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s &  sclk_d;
   assign cs_fall   = ~cs_n_s &  cs_n_d;
   assign cs_rise   =  cs_n_s & ~cs_n_d;

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   spi_state_e            state_q, state_d;
   logic                  buf_full;
   logic [DATA_WIDTH-1:0] tx_buf;
   // Bits still to be sent after the one currently on spi_miso.
   logic [DATA_WIDTH-2:0] tx_rem;
   // Bits of the current word received so far (the oldest shifts out at the
   // completing sample straight into rx_data).
   logic [DATA_WIDTH-2:0] rx_rem;
   logic [CW-1:0]         bit_cnt;
   logic                  reload_pending;

   // ---------------------------------------------------------------------
   // Next-state / action decode
   // ---------------------------------------------------------------------
   logic do_load;     // move buffer (or zeros) into the TX shifter
   logic do_shift;    // advance the TX shifter by one bit
   logic do_sample;   // capture mosi_s into the RX shifter
   logic go_idle;     // frame ended by CS_N rise

   always_comb begin
      state_d   = state_q;
      do_load   = 1'b0;
      do_shift  = 1'b0;
      do_sample = 1'b0;
      go_idle   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               do_load = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // CS_N rise has priority over a coincident SCLK rise: the frame
            // ends without taking that sample.
            if (cs_rise) begin
               go_idle = 1'b1;
               state_d = IDLE;
            end else begin
               if (sclk_rise) begin
                  do_sample = 1'b1;
               end
               if (sclk_fall) begin
                  if (reload_pending) begin
                     do_load = 1'b1;
                  end else begin
                     do_shift = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   logic [DATA_WIDTH-1:0] rx_word;
   assign rx_word = {rx_rem, mosi_s};

   // ---------------------------------------------------------------------
   // Sequential datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         buf_full       <= 1'b0;
         tx_buf         <= '0;
         tx_rem         <= '0;
         rx_rem         <= '0;
         bit_cnt        <= '0;
         reload_pending <= 1'b0;
         spi_miso       <= 1'b0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_valid <= 1'b0;

         // A write can only happen with the buffer empty, and a load only
         // empties a full buffer, so the two never touch buf_full together.
         // A write coinciding with an empty-buffer load is kept for the next
         // word while this load sends zeros.
         if (tx_valid && !buf_full) begin
            tx_buf   <= tx_data;
            buf_full <= 1'b1;
         end

         if (do_load) begin
            if (buf_full) begin
               spi_miso <= tx_buf[DATA_WIDTH-1];
               tx_rem   <= tx_buf[DATA_WIDTH-2:0];
               buf_full <= 1'b0;
            end else begin
               spi_miso <= 1'b0;
               tx_rem   <= '0;
            end
            reload_pending <= 1'b0;
         end

         if (do_shift) begin
            spi_miso <= tx_rem[DATA_WIDTH-2];
            tx_rem   <= tx_rem << 1;
         end

         if (do_sample) begin
            rx_rem <= rx_word[DATA_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
               rx_data        <= rx_word;
               rx_valid       <= 1'b1;
               bit_cnt        <= '0;
               reload_pending <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end

         // Partial word and any loaded TX word are dropped; the buffer keeps
         // whatever it holds for the next frame.
         if (go_idle) begin
            spi_miso       <= 1'b0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_underrun <= 1'b0;
         rx_abort    <= 1'b0;
      end else begin
         tx_underrun <= do_load && !buf_full;
         rx_abort    <= go_idle && (bit_cnt != '0);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign busy        = (state_q == ACTIVE);
   assign spi_miso_oe = (state_q == ACTIVE);
   assign tx_ready    = !buf_full;

endmodule : spi_slave_rx_tx

// File: tb/tb_spi_slave_rx_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx_tx
//   Drives SPI mode-0 frames into spi_slave_rx_tx (SCLK = clk/10). Expected RX
//   words and expected MISO words are pushed into queues as frames are issued;
//   independent monitors pop and compare on rx_valid and on every completed
//   MISO word. A one-deep buffer model decides what each load sends.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx_tx;

   localparam int W = 8;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         spi_sclk, spi_cs_n, spi_mosi;
   logic         spi_miso, spi_miso_oe;
   logic [W-1:0] tx_data;
   logic         tx_valid, tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid, busy;
`ifdef SPI_SLAVE_STATUS_EN
   logic         tx_underrun, rx_abort;
`endif

   spi_slave_rx_tx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy)
`ifdef SPI_SLAVE_STATUS_EN
      ,
      .tx_underrun(tx_underrun),
      .rx_abort   (rx_abort)
`endif
   );

   // ---------------------------------------------------------------------
   // Scoreboard state and reference model
   // ---------------------------------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] rx_exp_q[$];
   logic [W-1:0] miso_exp_q[$];

   bit           m_full = 1'b0;   // model of the one-deep TX buffer
   logic [W-1:0] m_buf  = '0;
   logic [W-1:0] m_last_rx = '0;
   int           m_underruns = 0;
   int           m_aborts = 0;
   int           rx_pulses = 0;

   logic [W-1:0] f_mosi[4];
   logic [W-1:0] f_tx[4];
   bit           f_sup[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // A load hands out the buffered word, or zeros when the buffer is empty.
   function automatic logic [W-1:0] model_load();
      logic [W-1:0] w;
      if (m_full) begin
         w      = m_buf;
         m_full = 1'b0;
      end else begin
         w = '0;
         m_underruns++;
      end
      return w;
   endfunction

   // ---------------------------------------------------------------------
   // Monitors
   // ---------------------------------------------------------------------
   always @(posedge clk) begin
      #1;
      if (!rst && rx_valid) begin
         rx_pulses++;
         if (rx_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_valid_unexpected: got rx_data 0x%0h, expected no pulse at %0t", rx_data, $time);
         end else begin
            check("rx_data", rx_data, rx_exp_q.pop_front());
         end
      end
   end

   int           mbits = 0;
   logic [W-1:0] mword = '0;

   always @(posedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         mbits = 0;
      end else begin
         mword = {mword[W-2:0], spi_miso};
         mbits++;
         if (mbits == W) begin
            mbits = 0;
            check("miso_oe", spi_miso_oe, 1);
            if (miso_exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL miso_word_unexpected: got 0x%0h, expected none at %0t", mword, $time);
            end else begin
               check("miso_word", mword, miso_exp_q.pop_front());
            end
         end
      end
   end

`ifdef SPI_SLAVE_STATUS_EN
   int d_under = 0;
   int d_abort = 0;
   always @(posedge clk) begin
      #1;
      if (tx_underrun) d_under++;
      if (rx_abort) d_abort++;
   end
`endif

   // ---------------------------------------------------------------------
   // Driver tasks (inputs change on the falling clk edge)
   // ---------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Takes exactly one clk cycle.
   task automatic write_tx(input logic [W-1:0] d);
      if (m_full) begin
         check("tx_ready_full", tx_ready, 0);
         @(negedge clk);
         return;
      end
      check("tx_ready_empty", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_buf    = d;
      check("tx_ready_after_write", tx_ready, 0);
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 4; i++) begin
         f_sup[i]  = 1'b0;
         f_tx[i]   = '0;
         f_mosi[i] = '0;
      end
   endtask

   task automatic random_frame();
      for (int i = 0; i < 4; i++) begin
         f_sup[i]  = ($urandom_range(0, 3) != 0);
         f_tx[i]   = W'($urandom);
         f_mosi[i] = W'($urandom);
      end
   endtask

   // Full frame of nw words, CS_N held low across them.
   task automatic run_frame(input int nw);
      logic [W-1:0] cur;
      if (f_sup[0]) begin
         write_tx(f_tx[0]);
      end
      @(negedge clk);
      spi_cs_n = 1'b0;
      cur = model_load();
      cyc(6);
      check("tx_ready_after_cs_fall", tx_ready, !m_full);
      check("busy_in_frame", busy, 1);
      for (int k = 0; k < nw; k++) begin
         miso_exp_q.push_back(cur);
         rx_exp_q.push_back(f_mosi[k]);
         m_last_rx = f_mosi[k];
         for (int b = 0; b < W; b++) begin
            spi_mosi = f_mosi[k][W-1-b];
            cyc(5);
            spi_sclk = 1'b1;
            if (b == 0 && k + 1 < nw && f_sup[k+1]) begin
               write_tx(f_tx[k+1]);
               cyc(4);
            end else begin
               cyc(5);
            end
            spi_sclk = 1'b0;
         end
         // The fall after the last bit always reloads the shifter.
         cur = model_load();
      end
      cyc(5);
      spi_cs_n = 1'b1;
      cyc(8);
      check("busy_after_frame", busy, 0);
   endtask

   // Frame cut after nbits bits of its first word, by CS_N rise or by rst.
   task automatic run_cut(input int nbits, input bit do_rst);
      logic [W-1:0] cur;
      if (f_sup[0]) begin
         write_tx(f_tx[0]);
      end
      @(negedge clk);
      spi_cs_n = 1'b0;
      cur = model_load();
      cyc(6);
      if (f_sup[1]) begin
         write_tx(f_tx[1]);   // stays buffered across the cut
      end
      for (int b = 0; b < nbits; b++) begin
         spi_mosi = f_mosi[0][W-1-b];
         cyc(5);
         spi_sclk = 1'b1;
         cyc(5);
         if (!(do_rst && b == nbits - 1)) begin
            spi_sclk = 1'b0;
         end
      end
      if (do_rst) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         check("rst_miso", spi_miso, 0);
         check("rst_miso_oe", spi_miso_oe, 0);
         check("rst_tx_ready", tx_ready, 1);
         check("rst_rx_data", rx_data, 0);
         check("rst_rx_valid", rx_valid, 0);
         check("rst_busy", busy, 0);
         cyc(2);
         spi_sclk = 1'b0;
         spi_cs_n = 1'b1;
         cyc(4);
         rst       = 1'b0;
         m_full    = 1'b0;
         m_last_rx = '0;
         cyc(4);
      end else begin
         cyc(5);
         spi_cs_n = 1'b1;
         m_aborts++;
         cyc(6);
         check("busy_after_abort", busy, 0);
         check("rx_data_kept", rx_data, m_last_rx);
         check("tx_ready_after_abort", tx_ready, !m_full);
         cyc(4);
      end
      if (cur != cur) begin
         n_bad++;   // unreachable: cur is always known
      end
   endtask

   // ---------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------
   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin
      int p0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      clear_frame();

      // Reset values while held in reset.
      cyc(5);
      check("reset_miso", spi_miso, 0);
      check("reset_miso_oe", spi_miso_oe, 0);
      check("reset_tx_ready", tx_ready, 1);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;

      // Idle: nothing happens for 100 cycles.
      p0 = rx_pulses;
      cyc(100);
      check("idle_rx_pulses", rx_pulses - p0, 0);
      check("idle_busy", busy, 0);
      check("idle_tx_ready", tx_ready, 1);
      check("idle_miso_oe", spi_miso_oe, 0);

      // Preload 0xA5, master sends 0x3C.
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'hA5; f_mosi[0] = 8'h3C;
      run_frame(1);

      // Two-word frame.
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'h12; f_mosi[0] = 8'h81;
      f_sup[1] = 1'b1; f_tx[1] = 8'h34; f_mosi[1] = 8'h7E;
      run_frame(2);

      // Underrun: nothing preloaded.
      clear_frame();
      f_mosi[0] = 8'hFF;
      run_frame(1);

      // Abort after 5 bits; a word written mid-frame survives in the buffer.
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'h99; f_mosi[0] = 8'hC6;
      f_sup[1] = 1'b1; f_tx[1] = 8'h66;
      run_cut(5, 1'b0);
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'hEE; f_mosi[0] = 8'h11;
      run_frame(1);

      // Reset at bit 3, then a fresh frame sending 0x55.
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'h5A; f_mosi[0] = 8'hB7;
      run_cut(3, 1'b1);
      clear_frame();
      f_sup[0] = 1'b1; f_tx[0] = 8'hC3; f_mosi[0] = 8'h55;
      run_frame(1);

      // Randomized frames.
      for (int i = 0; i < 25; i++) begin
         random_frame();
         if ($urandom_range(0, 5) == 0) begin
            run_cut($urandom_range(1, W - 1), 1'b0);
         end else begin
            run_frame($urandom_range(1, 3));
         end
      end

      // Drain and final checks.
      cyc(20);
      check("rx_queue_drained", rx_exp_q.size(), 0);
      check("miso_queue_drained", miso_exp_q.size(), 0);
      check("final_rx_data", rx_data, m_last_rx);
`ifdef SPI_SLAVE_STATUS_EN
      check("underrun_count", d_under, m_underruns);
      check("abort_count", d_abort, m_aborts);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_spi_slave_rx_tx

// File: doc/spi_slave_rx_tx.md
# spi_slave_rx_tx

SPI responder (slave) for mode 0 (CPOL=0, CPHA=0): oversamples the external SCLK, CS_N and MOSI pins on the system clock, deserializes MOSI into parallel words, and serializes a preloaded word onto MISO. It is the far end of our SPI master and its tick-based clock generator, used for loopback, board-to-board links and bench verification of the master. All logic runs in the `clk` domain; the pins are treated as asynchronous.

## Interface
- DATA_WIDTH, 8, word length in bits, MSB first; legal ≥ 2
- SYNC_STAGES, 2, synchronizer flops per input pin; legal ≥ 2
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- spi_sclk  input  1  serial clock from master, asynchronous
- spi_cs_n  input  1  chip select, active low, asynchronous
- spi_mosi  input  1  master-out data, asynchronous
- spi_miso  output  1  slave-out data
- spi_miso_oe  output  1  MISO output enable; high while synchronized CS_N low
- tx_data  input  DATA_WIDTH  next word to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  one-deep TX buffer empty
- rx_data  output  DATA_WIDTH  last complete received word
- rx_valid  output  1  one-cycle pulse, rx_data updated
- busy  output  1  state is ACTIVE

## Operation
- Each pin passes SYNC_STAGES flops; SCLK and CS_N get one further flop for edge detection (rise/fall strobes).
- TX buffer: write when tx_valid && tx_ready; tx_ready = !buf_full. Buffer is emptied when its word moves to the TX shift register (a "load").
- Load: TX shift ← buffer if full, else all zeros (underrun). If a write and a load coincide with the buffer empty, the load sends zeros and the written word stays in the buffer for the next word.
- States: IDLE, ACTIVE.
- IDLE: spi_miso=0, spi_miso_oe=0. CS_N fall strobe → load, bit_cnt=0, spi_miso = TX shift MSB, → ACTIVE.
- ACTIVE, SCLK rise: RX shift ← {RX shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++. When bit_cnt reaches DATA_WIDTH: rx_data ← completed word, rx_valid=1 for one cycle, bit_cnt=0, set reload_pending.
- ACTIVE, SCLK fall: if reload_pending, load and drive new MSB, clear reload_pending; else shift TX left and drive next bit.
- CS_N rise strobe in ACTIVE → IDLE from any bit count. Discard the partial word with no rx_valid. A word already loaded into TX shift is lost; the buffer is untouched.
- Multi-word frames: CS_N held low across words; words are back to back with no gap bit.
- rx_data is overwritten on every completed word. The consumer must take it on rx_valid.

## Timing
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0; state IDLE, buffer empty, counters and reload_pending 0.
- Pin edge to strobe: SYNC_STAGES+1 clk cycles.
- rx_valid asserts 1 cycle after the last-bit SCLK rise strobe.
- spi_miso updates on the cycle after the SCLK fall strobe (or the CS_N fall strobe).
- Requirement: SCLK high and low phases each ≥ SYNC_STAGES+3 clk cycles, and CS_N fall to first SCLK rise ≥ SYNC_STAGES+3 cycles. Otherwise behaviour is undefined.
- If SCLK rise and CS_N rise strobes fall in the same cycle, CS_N wins: no sample, → IDLE.
- rst mid-frame: immediate return to reset values. The frame resumes only on a fresh CS_N fall.

## Configuration
- SPI_SLAVE_STATUS_EN defined adds two outputs:
  - tx_underrun: 1-cycle pulse on each load with the buffer empty.
  - rx_abort: 1-cycle pulse when CS_N rises with bit_cnt≠0.
  - Both reset to 0.
- Undefined: neither port exists; underrun and abort happen silently as described above.

## Structure
- Package spi_pkg: state enum (IDLE, ACTIVE), default DATA_WIDTH and SYNC_STAGES localparams, shared with the master.
- Sub-module spi_sync (SYNC_STAGES-deep single-bit synchronizer), instantiated for sclk, cs_n and mosi.

## Test plan
- Reset, then idle: all outputs at reset values; tx_ready=1; no rx_valid over 100 cycles.
- Preload 0xA5, master sends 0x3C with SCLK=clk/10 → rx_data=0x3C with one rx_valid pulse; master receives 0xA5; tx_ready returns to 1 at CS_N fall.
- Two-word frame: buffer 0x12, then write 0x34 after tx_ready; master sends 0x81, 0x7E → rx_valid twice (0x81, 0x7E); MISO carries 0x12, 0x34.
- No preload, master sends 0xFF → MISO all zeros; rx_data=0xFF; tx_underrun pulses once when enabled.
- CS_N raised after 5 bits → no rx_valid; rx_data keeps its previous value; busy=0 after the strobe; rx_abort pulses once when enabled.
- rst asserted mid-word at bit 3 → all outputs at reset values on the next cycle; a new full frame sending 0x55 is received correctly.
